pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of all target buses.
REQ-002 Parameter BOOT_CYCLES, default 4, cycles held in BOOT after reset.
REQ-003 Parameter WAKE_CYCLES, default 2, cycles held in WAKE before RUN.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_ready  in  1  instruction memory accepts a fetch
- stall_req  in  1  decode hazard stall
- branch_taken  in  1  branch redirect request
- branch_target  in  PC_WIDTH  branch destination
- jump_req  in  1  jump redirect request
- jump_target  in  PC_WIDTH  jump destination
- exc_req  in  1  exception redirect request
- exc_vector  in  PC_WIDTH  exception destination
- sleep_req  in  1  request low-power sleep
- wake_irq  in  1  wake event
- pc_en  out  1  program counter update enable
- pc_sel  out  2  00 seq, 01 branch, 10 jump, 11 exception
- branch_target_o / jump_target_o / exc_vector_o  out  PC_WIDTH each  targets driven to the program counter
- flush  out  1  one-cycle pipeline flush pulse
- sleep_ack  out  1  high while in SLEEP
- state  out  3  current FSM state encoding

Function
REQ-005 FSM states SHALL be BOOT, RUN, STALL, SLEEP, WAKE.
REQ-006 BOOT: pc_en=0; down-counter loaded with BOOT_CYCLES-1; at count 0 go to RUN.
REQ-007 Redirect priority SHALL be exc_req > jump_req > branch_taken > sequential.
REQ-008 RUN, no stall_req, fetch_ready=1: pc_en=1 same cycle (combinational); pc_sel is the winning live request, or the pending request if one is held.
REQ-009 RUN with stall_req=1 or fetch_ready=0: pc_en=0; go to STALL; any live redirect is latched as pending.
REQ-010 Pending register SHALL hold one redirect (code plus target); a higher-priority request overwrites it, while an equal- or lower-priority request is ignored.
REQ-011 STALL: pc_en=0 until stall_req=0 and fetch_ready=1; that cycle pc_en=1 with the pending code (or 00), pending cleared, return to RUN.
REQ-012 exc_req SHALL bypass stall: in RUN or STALL, pc_en=1, pc_sel=11 that cycle, pending cleared, state RUN.
REQ-013 Target outputs SHALL be the latched value when that code is pending, otherwise the live input.
REQ-014 flush SHALL be registered: high for exactly one cycle after any cycle with pc_en=1 and pc_sel!=00.
REQ-015 sleep_req in RUN with no pending and no live redirect: go to SLEEP next cycle; pc_en=0; sleep_ack=1.
REQ-016 SLEEP: wake_irq or exc_req goes to WAKE; exc_req is latched as pending.
REQ-017 WAKE: pc_en=0 for WAKE_CYCLES cycles, then RUN; a pending exception is applied on the first RUN cycle.
REQ-018 sleep_req together with any redirect SHALL be ignored that cycle, so the redirect wins.

Reset
REQ-019 rst=1 SHALL immediately force BOOT, counter=BOOT_CYCLES-1, pending cleared, pc_en=0, pc_sel=00, flush=0, sleep_ack=0, target outputs 0.
REQ-020 rst asserted mid-operation (any state, including a pending redirect) SHALL discard all state.

Structure
REQ-021 State encoding and pc_sel codes SHALL live in shared package pc_ctrl_pkg, which program_counter users also import.
REQ-022 The shared down-counter for BOOT and WAKE SHALL be one sub-module, seq_delay_counter.

Verification
REQ-023 Reset release: pc_en=0 for exactly 4 cycles, then state=RUN and pc_en=1, pc_sel=00.
REQ-024 branch_taken=1 and jump_req=1 in the same cycle (targets 0x0040, 0x0080): pc_sel=10, jump_target_o=0x0080, flush=1 next cycle.
REQ-025 stall_req held 3 cycles with branch_taken pulsed in stall cycle 1 (target 0x0100): pc_en=0 for 3 cycles, then pc_sel=01, branch_target_o=0x0100, flush follows.
REQ-026 During that stall, jump_req pulsed in cycle 2, then exc_req in cycle 3 (vector 0x0002): exc_req applies immediately in cycle 3 (REQ-012), pending cleared, branch lost.
REQ-027 sleep_req, then wake_irq 5 cycles later: sleep_ack=1 for those 5 cycles, WAKE for 2 cycles, then RUN with pc_en=1.
REQ-028 rst pulsed while a branch is pending in STALL: after release, BOOT sequence repeats and no redirect is issued.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared control definitions for the PC sequencer and every block that
// drives or consumes the program counter select bus.
package pc_ctrl_pkg;

  // Sequencer FSM state encoding, visible on the state output.
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } seq_state_e;

  // Program counter source select. Codes are ordered so that a larger
  // numeric value is a higher-priority redirect; outranks() relies on this.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_EXC    = 2'b11
  } pc_sel_e;

  // Pick the winning live redirect: exception > jump > branch > sequential.
  function automatic pc_sel_e resolve_redirect(input logic exc,
                                               input logic jump,
                                               input logic branch);
    if (exc) begin
      return SEL_EXC;
    end else if (jump) begin
      return SEL_JUMP;
    end else if (branch) begin
      return SEL_BRANCH;
    end
    return SEL_SEQ;
  endfunction

  // True when challenger has strictly higher priority than holder.
  function automatic logic outranks(input pc_sel_e challenger,
                                    input pc_sel_e holder);
    return challenger > holder;
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Saturating down-counter shared by the BOOT and WAKE hold-off intervals.
// load takes priority over dec; dec stops at zero.
module seq_delay_counter #(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count register: reload on request, otherwise count down to zero.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: boots, arbitrates redirects, holds one
// pending redirect across stalls, and manages sleep/wake. pc_en and
// pc_sel are decoded combinationally so the PC updates in the same cycle;
// flush and sleep_ack are registered.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int BOOT_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_ready,
  input  logic                stall_req,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump_req,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                exc_req,
  input  logic [PC_WIDTH-1:0] exc_vector,
  input  logic                sleep_req,
  input  logic                wake_irq,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic [PC_WIDTH-1:0] branch_target_o,
  output logic [PC_WIDTH-1:0] jump_target_o,
  output logic [PC_WIDTH-1:0] exc_vector_o,
  output logic                flush,
  output logic                sleep_ack,
  output logic [2:0]          state
);

  localparam int CNT_MAX = (BOOT_CYCLES > WAKE_CYCLES) ? BOOT_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  seq_state_e          state_q;
  seq_state_e          state_d;
  pc_sel_e             pend_code_q;
  logic [PC_WIDTH-1:0] pend_target_q;
  pc_sel_e             live_code;
  logic [PC_WIDTH-1:0] live_target;
  pc_sel_e             merged_code;
  pc_sel_e             pc_sel_d;
  logic                exc_now;
  logic                pend_clear;
  logic                pend_capture;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_dec;
  logic                cnt_done;

  seq_delay_counter #(
    .WIDTH       (CNT_W),
    .RESET_VALUE (BOOT_LOAD)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_load_val),
    .dec        (cnt_dec),
    .done       (cnt_done)
  );

  // Resolve the live redirect and its target address.
  always_comb begin
    live_code = resolve_redirect(exc_req, jump_req, branch_taken);
    case (live_code)
      SEL_EXC:    live_target = exc_vector;
      SEL_JUMP:   live_target = jump_target;
      SEL_BRANCH: live_target = branch_target;
      default:    live_target = '0;
    endcase
  end

  // A held redirect is only displaced by a strictly higher-priority one.
  assign merged_code = outranks(live_code, pend_code_q) ? live_code : pend_code_q;

  // Exceptions, live or held from sleep, bypass any stall.
  assign exc_now = exc_req || (pend_code_q == SEL_EXC);

  // Next-state, PC enable/select and pending/counter control decode.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    pc_sel_d     = SEL_SEQ;
    pend_clear   = 1'b0;
    pend_capture = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_d = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (exc_now) begin
          pc_en      = 1'b1;
          pc_sel_d   = SEL_EXC;
          pend_clear = 1'b1;
          state_d    = ST_RUN;
        end else if (stall_req || !fetch_ready) begin
          pend_capture = 1'b1;
          state_d      = ST_STALL;
        end else if ((state_q == ST_RUN) && sleep_req && (merged_code == SEL_SEQ)) begin
          // Sleep entry issues no fetch; the core goes quiet immediately.
          state_d = ST_SLEEP;
        end else begin
          pc_en      = 1'b1;
          pc_sel_d   = merged_code;
          pend_clear = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_SLEEP: begin
        // Only an exception is worth remembering across the wake-up.
        pend_capture = exc_req;
        if (wake_irq || exc_req) begin
          state_d      = ST_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // Redirects arriving while waking are held for the first RUN cycle.
        pend_capture = 1'b1;
        cnt_dec      = 1'b1;
        if (cnt_done) state_d = ST_RUN;
      end
      default: begin
        state_d      = ST_BOOT;
        cnt_load     = 1'b1;
        cnt_load_val = BOOT_LOAD;
      end
    endcase
  end

  // FSM state, pending redirect and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pend_code_q   <= SEL_SEQ;
      pend_target_q <= '0;
      flush         <= 1'b0;
      sleep_ack     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sleep_ack <= (state_d == ST_SLEEP);
      flush     <= pc_en && (pc_sel_d != SEL_SEQ);
      if (pend_clear) begin
        pend_code_q <= SEL_SEQ;
      end else if (pend_capture && outranks(live_code, pend_code_q)) begin
        pend_code_q   <= live_code;
        pend_target_q <= live_target;
      end
    end
  end

  assign pc_sel = pc_sel_d;
  assign state  = state_q;

  // Targets show the held address for a pending code, else the live input;
  // all are forced to zero while reset is asserted.
  assign branch_target_o = rst ? '0 :
                           (pend_code_q == SEL_BRANCH) ? pend_target_q : branch_target;
  assign jump_target_o   = rst ? '0 :
                           (pend_code_q == SEL_JUMP) ? pend_target_q : jump_target;
  assign exc_vector_o    = rst ? '0 :
                           (pend_code_q == SEL_EXC) ? pend_target_q : exc_vector;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_pc_sequencer;
  import pc_ctrl_pkg::*;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_ready = 1'b1;
  logic          stall_req = 1'b0;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          jump_req = 1'b0;
  logic [PW-1:0] jump_target = '0;
  logic          exc_req = 1'b0;
  logic [PW-1:0] exc_vector = '0;
  logic          sleep_req = 1'b0;
  logic          wake_irq = 1'b0;
  logic          pc_en;
  logic [1:0]    pc_sel;
  logic [PW-1:0] branch_target_o;
  logic [PW-1:0] jump_target_o;
  logic [PW-1:0] exc_vector_o;
  logic          flush;
  logic          sleep_ack;
  logic [2:0]    state;

  int passed = 0;
  int total  = 0;

  pc_sequencer #(.PC_WIDTH(PW), .BOOT_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_ready     (fetch_ready),
    .stall_req       (stall_req),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump_req        (jump_req),
    .jump_target     (jump_target),
    .exc_req         (exc_req),
    .exc_vector      (exc_vector),
    .sleep_req       (sleep_req),
    .wake_irq        (wake_irq),
    .pc_en           (pc_en),
    .pc_sel          (pc_sel),
    .branch_target_o (branch_target_o),
    .jump_target_o   (jump_target_o),
    .exc_vector_o    (exc_vector_o),
    .flush           (flush),
    .sleep_ack       (sleep_ack),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    fetch_ready  = 1'b1;
    stall_req    = 1'b0;
    branch_taken = 1'b0;
    jump_req     = 1'b0;
    exc_req      = 1'b0;
    sleep_req    = 1'b0;
    wake_irq     = 1'b0;
  endtask

  // Release reset at a falling edge and expect exactly four idle cycles.
  task automatic boot_sequence(input string tag);
    int zeros = 0;
    bit seen  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (pc_en === 1'b1) seen = 1'b1;
      else zeros++;
    end
    total++; if (!seen || zeros != 4) $display("FAIL %s_boot_len got %0d idle cycles (en seen %0b) exp 4", tag, zeros, seen); else passed++;
    total++; if (state !== ST_RUN) $display("FAIL %s_boot_state got %0d exp %0d", tag, state, ST_RUN); else passed++;
    total++; if (pc_sel !== 2'b00) $display("FAIL %s_boot_sel got %b exp 00", tag, pc_sel); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    exc_req       = 1'b1;
    branch_target = 16'h1234;
    jump_target   = 16'h5678;
    exc_vector    = 16'h9ABC;
    @(negedge clk); #1;
    total++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en got %b exp 0", pc_en); else passed++;
    total++; if (pc_sel !== 2'b00) $display("FAIL rst_pc_sel got %b exp 00", pc_sel); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL rst_flush got %b exp 0", flush); else passed++;
    total++; if (sleep_ack !== 1'b0) $display("FAIL rst_sleep_ack got %b exp 0", sleep_ack); else passed++;
    total++; if (state !== ST_BOOT) $display("FAIL rst_state got %0d exp %0d", state, ST_BOOT); else passed++;
    total++; if (branch_target_o !== 16'h0) $display("FAIL rst_branch_o got %h exp 0000", branch_target_o); else passed++;
    total++; if (jump_target_o !== 16'h0) $display("FAIL rst_jump_o got %h exp 0000", jump_target_o); else passed++;
    total++; if (exc_vector_o !== 16'h0) $display("FAIL rst_exc_o got %h exp 0000", exc_vector_o); else passed++;
    exc_req = 1'b0;
    boot_sequence("reset");
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle_inputs();
    branch_taken = 1'b1; branch_target = 16'h0040;
    jump_req = 1'b1;     jump_target = 16'h0080;
    #1;
    total++; if (pc_en !== 1'b1) $display("FAIL prio_pc_en got %b exp 1", pc_en); else passed++;
    total++; if (pc_sel !== 2'b10) $display("FAIL prio_pc_sel got %b exp 10", pc_sel); else passed++;
    total++; if (jump_target_o !== 16'h0080) $display("FAIL prio_jump_o got %h exp 0080", jump_target_o); else passed++;
    @(negedge clk); idle_inputs(); #1;
    total++; if (flush !== 1'b1) $display("FAIL prio_flush got %b exp 1", flush); else passed++;
    @(negedge clk); #1;
    total++; if (flush !== 1'b0) $display("FAIL prio_flush_drop got %b exp 0", flush); else passed++;
  endtask

  task automatic test_stall_branch();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_inputs();
      stall_req = 1'b1;
      if (c == 1) begin branch_taken = 1'b1; branch_target = 16'h0100; end
      else branch_target = 16'h0ABC;
      #1;
      total++; if (pc_en !== 1'b0) $display("FAIL stall_pc_en_c%0d got %b exp 0", c, pc_en); else passed++;
      if (c > 1) begin
        total++; if (branch_target_o !== 16'h0100) $display("FAIL stall_held_tgt_c%0d got %h exp 0100", c, branch_target_o); else passed++;
      end
    end
    @(negedge clk); idle_inputs(); #1;
    total++; if (pc_en !== 1'b1) $display("FAIL stall_release_en got %b exp 1", pc_en); else passed++;
    total++; if (pc_sel !== 2'b01) $display("FAIL stall_release_sel got %b exp 01", pc_sel); else passed++;
    total++; if (branch_target_o !== 16'h0100) $display("FAIL stall_release_tgt got %h exp 0100", branch_target_o); else passed++;
    @(negedge clk); #1;
    total++; if (flush !== 1'b1) $display("FAIL stall_flush got %b exp 1", flush); else passed++;
    total++; if (state !== ST_RUN) $display("FAIL stall_back_run got %0d exp %0d", state, ST_RUN); else passed++;
  endtask

  task automatic test_stall_exc();
    @(negedge clk); idle_inputs();
    stall_req = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100; #1;
    @(negedge clk); idle_inputs();
    stall_req = 1'b1; jump_req = 1'b1; jump_target = 16'h0200; #1;
    total++; if (pc_en !== 1'b0) $display("FAIL sexc_c2_en got %b exp 0", pc_en); else passed++;
    @(negedge clk); idle_inputs();
    stall_req = 1'b1; exc_req = 1'b1; exc_vector = 16'h0002; #1;
    total++; if (pc_en !== 1'b1) $display("FAIL sexc_c3_en got %b exp 1", pc_en); else passed++;
    total++; if (pc_sel !== 2'b11) $display("FAIL sexc_c3_sel got %b exp 11", pc_sel); else passed++;
    total++; if (exc_vector_o !== 16'h0002) $display("FAIL sexc_c3_vec got %h exp 0002", exc_vector_o); else passed++;
    @(negedge clk); idle_inputs(); branch_target = 16'h0777; #1;
    total++; if (flush !== 1'b1) $display("FAIL sexc_flush got %b exp 1", flush); else passed++;
    total++; if (state !== ST_RUN) $display("FAIL sexc_state got %0d exp %0d", state, ST_RUN); else passed++;
    total++; if (pc_sel !== 2'b00) $display("FAIL sexc_branch_lost_sel got %b exp 00", pc_sel); else passed++;
    total++; if (branch_target_o !== 16'h0777) $display("FAIL sexc_pend_clear got %h exp 0777", branch_target_o); else passed++;
  endtask

  task automatic test_sleep();
    @(negedge clk); idle_inputs(); sleep_req = 1'b1; #1;
    total++; if (state !== ST_RUN) $display("FAIL sleep_req_state got %0d exp %0d", state, ST_RUN); else passed++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); idle_inputs();
      if (k == 5) wake_irq = 1'b1;
      #1;
      total++; if (sleep_ack !== 1'b1) $display("FAIL sleep_ack_c%0d got %b exp 1", k, sleep_ack); else passed++;
      total++; if (state !== ST_SLEEP) $display("FAIL sleep_state_c%0d got %0d exp %0d", k, state, ST_SLEEP); else passed++;
      total++; if (pc_en !== 1'b0) $display("FAIL sleep_en_c%0d got %b exp 0", k, pc_en); else passed++;
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); idle_inputs(); #1;
      total++; if (state !== ST_WAKE) $display("FAIL wake_state_c%0d got %0d exp %0d", k, state, ST_WAKE); else passed++;
      total++; if (pc_en !== 1'b0) $display("FAIL wake_en_c%0d got %b exp 0", k, pc_en); else passed++;
      total++; if (sleep_ack !== 1'b0) $display("FAIL wake_ack_c%0d got %b exp 0", k, sleep_ack); else passed++;
    end
    @(negedge clk); idle_inputs(); #1;
    total++; if (state !== ST_RUN) $display("FAIL wake_run_state got %0d exp %0d", state, ST_RUN); else passed++;
    total++; if (pc_en !== 1'b1) $display("FAIL wake_run_en got %b exp 1", pc_en); else passed++;

    // Exception wakes the core and is applied on the first RUN cycle.
    @(negedge clk); idle_inputs(); sleep_req = 1'b1; #1;
    @(negedge clk); idle_inputs(); exc_req = 1'b1; exc_vector = 16'h0002; #1;
    total++; if (pc_en !== 1'b0) $display("FAIL sleep_exc_en got %b exp 0", pc_en); else passed++;
    @(negedge clk); idle_inputs(); exc_vector = 16'hDEAD; #1;
    total++; if (state !== ST_WAKE) $display("FAIL sleep_exc_wake got %0d exp %0d", state, ST_WAKE); else passed++;
    @(negedge clk); idle_inputs(); #1;
    @(negedge clk); idle_inputs(); #1;
    total++; if (pc_en !== 1'b1 || pc_sel !== 2'b11) $display("FAIL sleep_exc_apply got en=%b sel=%b exp en=1 sel=11", pc_en, pc_sel); else passed++;
    total++; if (exc_vector_o !== 16'h0002) $display("FAIL sleep_exc_vec got %h exp 0002", exc_vector_o); else passed++;

    // Sleep request alongside a redirect is ignored.
    @(negedge clk); idle_inputs(); sleep_req = 1'b1; branch_taken = 1'b1; branch_target = 16'h0300; #1;
    total++; if (pc_en !== 1'b1 || pc_sel !== 2'b01) $display("FAIL sleep_redir got en=%b sel=%b exp en=1 sel=01", pc_en, pc_sel); else passed++;
    @(negedge clk); idle_inputs(); #1;
    total++; if (state !== ST_RUN || sleep_ack !== 1'b0) $display("FAIL sleep_redir_state got st=%0d ack=%b exp st=%0d ack=0", state, sleep_ack, ST_RUN); else passed++;
  endtask

  task automatic test_reset_pending();
    @(negedge clk); idle_inputs(); stall_req = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100; #1;
    @(negedge clk); idle_inputs(); stall_req = 1'b1; branch_target = 16'h0555; #1;
    total++; if (state !== ST_STALL || branch_target_o !== 16'h0100) $display("FAIL rpend_setup got st=%0d tgt=%h exp st=%0d tgt=0100", state, branch_target_o, ST_STALL); else passed++;
    rst = 1'b1; #1;
    total++; if (state !== ST_BOOT) $display("FAIL rpend_async_state got %0d exp %0d", state, ST_BOOT); else passed++;
    total++; if (pc_en !== 1'b0 || branch_target_o !== 16'h0) $display("FAIL rpend_async_out got en=%b tgt=%h exp en=0 tgt=0000", pc_en, branch_target_o); else passed++;
    boot_sequence("rst_pend");
    total++; if (branch_target_o !== 16'h0555) $display("FAIL rpend_no_held_tgt got %h exp 0555", branch_target_o); else passed++;
    @(negedge clk); idle_inputs(); #1;
    total++; if (flush !== 1'b0) $display("FAIL rpend_flush got %b exp 0", flush); else passed++;
  endtask

  // Randomized stall/redirect traffic against a reference model.
  task automatic test_random();
    seq_state_e    m_state = ST_RUN;
    int            m_pend  = 0;
    logic [PW-1:0] m_tgt   = '0;
    bit            m_flush = 1'b0;
    int            live;
    int            e_sel;
    bit            e_en;
    logic [PW-1:0] e_bt, e_jt, e_ev;
    rst = 1'b1;
    @(negedge clk);
    boot_sequence("rand");
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      idle_inputs();
      fetch_ready   = ($urandom_range(0, 9) < 8);
      stall_req     = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      jump_req      = ($urandom_range(0, 6) == 0);
      exc_req       = ($urandom_range(0, 19) == 0);
      branch_target = 16'($urandom);
      jump_target   = 16'($urandom);
      exc_vector    = 16'($urandom);
      #1;
      live = exc_req ? 3 : jump_req ? 2 : branch_taken ? 1 : 0;
      e_bt = (m_pend == 1) ? m_tgt : branch_target;
      e_jt = (m_pend == 2) ? m_tgt : jump_target;
      e_ev = (m_pend == 3) ? m_tgt : exc_vector;
      if (exc_req || m_pend == 3) begin
        e_en = 1'b1; e_sel = 3;
      end else if (stall_req || !fetch_ready) begin
        e_en = 1'b0; e_sel = 0;
      end else begin
        e_en = 1'b1; e_sel = (live > m_pend) ? live : m_pend;
      end
      total++; if (state !== m_state) $display("FAIL rand_state cyc %0d got %0d exp %0d", c, state, m_state); else passed++;
      total++; if (pc_en !== e_en) $display("FAIL rand_pc_en cyc %0d got %b exp %b", c, pc_en, e_en); else passed++;
      total++; if (pc_sel !== 2'(e_sel)) $display("FAIL rand_pc_sel cyc %0d got %b exp %0d", c, pc_sel, e_sel); else passed++;
      total++; if (flush !== m_flush) $display("FAIL rand_flush cyc %0d got %b exp %b", c, flush, m_flush); else passed++;
      total++; if (branch_target_o !== e_bt) $display("FAIL rand_branch_o cyc %0d got %h exp %h", c, branch_target_o, e_bt); else passed++;
      total++; if (jump_target_o !== e_jt) $display("FAIL rand_jump_o cyc %0d got %h exp %h", c, jump_target_o, e_jt); else passed++;
      total++; if (exc_vector_o !== e_ev) $display("FAIL rand_exc_o cyc %0d got %h exp %h", c, exc_vector_o, e_ev); else passed++;
      if (e_en) begin
        m_pend  = 0;
        m_state = ST_RUN;
      end else begin
        if (live > m_pend) begin
          m_pend = live;
          m_tgt  = (live == 1) ? branch_target : (live == 2) ? jump_target : exc_vector;
        end
        m_state = ST_STALL;
      end
      m_flush = e_en && (e_sel != 0);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stall_branch();
    test_stall_exc();
    test_sleep();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached after %0d of %0d checks passed", passed, total);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
